score_sequencer: RTL and testbench
==================================

SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 Parameter WINDOW_CYCLES, default 1000000, SHALL set the hit-window length in clk cycles; legal range 2..2^24-1.
REQ-002 Parameter SCORE_W, default 16, SHALL set the score width.
REQ-003 Parameters HIT_POINTS (default 10) and MISS_PENALTY (default 5) SHALL set score deltas, each < 2^SCORE_W.
REQ-004 Port list:
  clk  in  1  sole clock, rising edge.
  resetn  in  1  synchronous active-low reset.
  beat_tick  in  1  one-cycle pulse; a new note slot has reached the hit line.
  notes  in  3  lowest bit of each of the three note registers, valid while beat_tick is high.
  player_input  in  3  player buttons, already synchronous to clk, 1 = pressed.
  score  out  SCORE_W  current score.
  combo  out  8  consecutive-hit count.
  hit_pulse  out  1  one-cycle pulse: slot judged as a hit.
  miss_pulse  out  1  one-cycle pulse: slot judged as a miss.
  busy  out  1  high while not IDLE.
  overrun  out  1  sticky: beat_tick arrived while busy.

Function
REQ-005 The FSM SHALL have three states: IDLE, WINDOW, JUDGE.
REQ-006 IDLE: on beat_tick=1, latch notes into note_q, clear cap_q, clear the window counter, and go to WINDOW.
REQ-007 Rising-edge detection: edge = player_input & ~prev_q; prev_q updates every cycle in every state.
REQ-008 WINDOW: each cycle, cap_q |= edge; the counter increments; at count WINDOW_CYCLES-1, go to JUDGE.
REQ-009 Judgement SHALL use cap_final = cap_q | edge of the last WINDOW cycle, so presses on the last cycle count.
REQ-010 Judgement rules:
  - hit: note_q != 000 and cap_final == note_q.
  - neutral: note_q == 000 and cap_final == 000.
  - miss: all other cases.
REQ-011 On the edge entering JUDGE, the registered effects SHALL apply together:
  - hit: hit_pulse=1; score += hit delta, saturating at 2^SCORE_W-1; combo += 1, saturating at 255.
  - miss: miss_pulse=1; score -= MISS_PENALTY, saturating at 0; combo = 0.
  - neutral: no pulse; score and combo unchanged.
REQ-012 JUDGE SHALL last exactly one cycle, then go to IDLE; hit_pulse and miss_pulse SHALL be low in every other cycle.
REQ-013 Latency: beat_tick sampled at edge T gives WINDOW cycles T+1..T+WINDOW_CYCLES and JUDGE at cycle T+WINDOW_CYCLES+1, with pulses and the new score visible in that cycle.
REQ-014 beat_tick in WINDOW or JUDGE SHALL be ignored for sequencing and SHALL set overrun; overrun clears only on reset.
REQ-015 A new slot SHALL start only from IDLE, so beat_tick spacing of at least WINDOW_CYCLES+2 cycles is required for no overrun.
REQ-016 hit_pulse and miss_pulse SHALL never be high in the same cycle.

Reset
REQ-017 When resetn=0 at a clk edge:
  - state = IDLE; score = 0; combo = 0; hit_pulse = miss_pulse = overrun = 0.
  - cap_q = 000; note_q = 000; counter = 0; prev_q = 111 (buttons held through reset produce no edge).
REQ-018 Reset mid-WINDOW SHALL abandon the slot with no pulse and no score change.

Configuration
REQ-019 Macro SCORE_COMBO_BONUS_EN defined: hit delta = HIT_POINTS + (combo >> 3), using combo before the increment.
REQ-020 Macro SCORE_COMBO_BONUS_EN undefined: hit delta = HIT_POINTS; the combo counter still operates.

Structure
REQ-021 Shared package score_seq_pkg SHALL hold:
  - the FSM state encoding;
  - the judgement result encoding (HIT/MISS/NEUTRAL);
  - default constants for WINDOW_CYCLES, HIT_POINTS and MISS_PENALTY.
REQ-022 Sub-module input_edge_capture SHALL contain prev_q, the edge logic and cap_q, with clear and enable inputs.
REQ-023 Score and combo saturation arithmetic SHALL stay in score_sequencer.

Verification (WINDOW_CYCLES=4, SCORE_W=16, bonus undefined unless stated)
REQ-024 Hit: notes=111 at beat_tick; player_input goes 000->111 in window cycle 2 -> hit_pulse at T+5, score 0->10, combo 0->1.
REQ-025 Wrong and missing presses:
  - notes=101, press 001 only -> miss_pulse, score stays 0 (saturates), combo=0.
  - notes=000, press 010 -> miss_pulse.
  - notes=000, no press -> no pulse, score unchanged.
REQ-026 Held button: player_input=111 held from before beat_tick through the window, notes=111 -> miss (no rising edge); a rising edge on the last window cycle -> hit.
REQ-027 Saturation: preload via 6554 hits -> score=65535, stays 65535 on next hit; 256 consecutive hits -> combo=255.
REQ-028 With SCORE_COMBO_BONUS_EN: combo=16 then hit -> score += 12.
REQ-029 Overrun and reset:
  - beat_tick two cycles after a prior tick -> overrun=1, judgement timing of the first slot unchanged.
  - resetn=0 in window cycle 3 -> no pulse, all outputs 0.

Source files
------------

// File: rtl/score_seq_pkg.sv
// Shared types and defaults for the rhythm-game score sequencer: FSM states,
// judgement results, default timing/score constants and the slot judgement rule.
package score_seq_pkg;

    localparam int DEF_WINDOW_CYCLES = 1000000;
    localparam int DEF_HIT_POINTS    = 10;
    localparam int DEF_MISS_PENALTY  = 5;
    localparam int CNT_W             = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_JUDGE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        JR_NEUTRAL = 2'd0,
        JR_HIT     = 2'd1,
        JR_MISS    = 2'd2
    } judge_t;

    // An empty slot is only neutral if nothing was pressed; otherwise presses must match exactly.
    function automatic judge_t judge_slot(input logic [2:0] note, input logic [2:0] cap);
        judge_t r;
        if (note == 3'b000) begin
            if (cap == 3'b000) begin
                r = JR_NEUTRAL;
            end else begin
                r = JR_MISS;
            end
        end else if (cap == note) begin
            r = JR_HIT;
        end else begin
            r = JR_MISS;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_edge_capture.sv
// Button rising-edge detector with a clearable capture register; cap_final
// folds in the current cycle's edges so a press on the last window cycle counts.
module input_edge_capture (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    input  logic [2:0] player_input,
    output logic [2:0] cap_final
);

    logic [2:0] prev_q;
    logic [2:0] prev_d;
    logic [2:0] cap_q;
    logic [2:0] cap_d;
    logic [2:0] edge_s;

    // Edge detection and capture next-state
    always_comb begin
        edge_s = player_input & ~prev_q;
        prev_d = player_input;
        if (clear) begin
            cap_d = 3'b000;
        end else if (enable) begin
            cap_d = cap_q | edge_s;
        end else begin
            cap_d = cap_q;
        end
    end

    assign cap_final = cap_q | edge_s;

    // prev resets to all-pressed so buttons held through reset give no edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q <= 3'b111;
            cap_q  <= 3'b000;
        end else begin
            prev_q <= prev_d;
            cap_q  <= cap_d;
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Rhythm-game slot sequencer: opens a hit window per beat_tick, judges the
// captured presses and updates a saturating score and combo.
// Optional macro SCORE_COMBO_BONUS_EN adds (combo >> 3) to every hit.
module score_sequencer
    import score_seq_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int SCORE_W       = 16,
    parameter int HIT_POINTS    = DEF_HIT_POINTS,
    parameter int MISS_PENALTY  = DEF_MISS_PENALTY
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               beat_tick,
    input  logic [2:0]         notes,
    input  logic [2:0]         player_input,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               busy,
    output logic               overrun
);

    localparam int SUM_W = SCORE_W + 2;
    localparam logic [SUM_W-1:0] SCORE_MAX_EXT = SUM_W'({SCORE_W{1'b1}});
    localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(WINDOW_CYCLES - 1);

    state_t             state_q, state_d;
    logic [2:0]         note_q, note_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         combo_q, combo_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic               cap_clear_s;
    logic               cap_en_s;
    logic [2:0]         cap_final_s;
    judge_t             result_s;
    logic [SUM_W-1:0]   hit_delta_s;
    logic [SUM_W-1:0]   hit_sum_s;

    input_edge_capture u_capture (
        .clk          (clk),
        .resetn       (resetn),
        .clear        (cap_clear_s),
        .enable       (cap_en_s),
        .player_input (player_input),
        .cap_final    (cap_final_s)
    );

    // Hit delta, optionally boosted by the pre-increment combo
    always_comb begin
`ifdef SCORE_COMBO_BONUS_EN
        hit_delta_s = SUM_W'(HIT_POINTS) + SUM_W'(combo_q >> 3);
`else
        hit_delta_s = SUM_W'(HIT_POINTS);
`endif
        hit_sum_s = {2'b00, score_q} + hit_delta_s;
    end

    // Sequencing, judgement and saturating score/combo next-state
    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        combo_d     = combo_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        cap_clear_s = 1'b0;
        cap_en_s    = 1'b0;
        result_s    = JR_NEUTRAL;
        overrun_d   = overrun_q | (beat_tick & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (beat_tick) begin
                    note_d      = notes;
                    cnt_d       = {CNT_W{1'b0}};
                    cap_clear_s = 1'b1;
                    state_d     = ST_WINDOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WINDOW: begin
                cap_en_s = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    result_s = judge_slot(note_q, cap_final_s);
                    state_d  = ST_JUDGE;
                    case (result_s)
                        JR_HIT: begin
                            hit_d = 1'b1;
                            if (hit_sum_s > SCORE_MAX_EXT) begin
                                score_d = {SCORE_W{1'b1}};
                            end else begin
                                score_d = hit_sum_s[SCORE_W-1:0];
                            end
                            if (combo_q == 8'hFF) begin
                                combo_d = 8'hFF;
                            end else begin
                                combo_d = combo_q + 8'd1;
                            end
                        end
                        JR_MISS: begin
                            miss_d  = 1'b1;
                            combo_d = 8'd0;
                            if (score_q >= SCORE_W'(MISS_PENALTY)) begin
                                score_d = score_q - SCORE_W'(MISS_PENALTY);
                            end else begin
                                score_d = {SCORE_W{1'b0}};
                            end
                        end
                        default: begin
                            score_d = score_q;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_JUDGE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            note_q    <= 3'b000;
            cnt_q     <= {CNT_W{1'b0}};
            score_q   <= {SCORE_W{1'b0}};
            combo_q   <= 8'd0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            combo_q   <= combo_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Randomized + directed bench for score_sequencer (WINDOW_CYCLES=4) against a
// slot-level reference model of score, combo and judgement.
module tb_score_sequencer;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        beat_tick;
    logic [2:0]  notes;
    logic [2:0]  player_input;
    logic [15:0] score;
    logic [7:0]  combo;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    int m_score   = 0;
    int m_combo   = 0;
    int m_overrun = 0;

    logic [2:0] seq_a [0:W];

    score_sequencer #(.WINDOW_CYCLES(W), .SCORE_W(16), .HIT_POINTS(10), .MISS_PENALTY(5)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .beat_tick    (beat_tick),
        .notes        (notes),
        .player_input (player_input),
        .score        (score),
        .combo        (combo),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected judgement for the current seq_a and notes; returns 1=hit 2=miss 0=neutral.
    function automatic int model_judge(input logic [2:0] nv);
        logic [2:0] cap;
        cap = 3'b000;
        for (int k = 1; k <= W; k++) cap = cap | (seq_a[k] & ~seq_a[k-1]);
        if (nv != 3'b000 && cap == nv) return 1;
        if (nv == 3'b000 && cap == 3'b000) return 0;
        return 2;
    endfunction

    task automatic model_apply(input int res);
        int delta;
        if (res == 1) begin
            delta = 10;
`ifdef SCORE_COMBO_BONUS_EN
            delta = delta + m_combo / 8;
`endif
            m_score = (m_score + delta > 65535) ? 65535 : m_score + delta;
            m_combo = (m_combo == 255) ? 255 : m_combo + 1;
        end else if (res == 2) begin
            m_score = (m_score < 5) ? 0 : m_score - 5;
            m_combo = 0;
        end
    endtask

    // One slot: tick in the current (idle) cycle, W window cycles, judge cycle, back to idle.
    task automatic run_slot(input logic [2:0] nv);
        int res;
        res = model_judge(nv);
        beat_tick    = 1'b1;
        notes        = nv;
        player_input = seq_a[0];
        step();
        beat_tick = 1'b0;
        notes     = 3'($urandom);
        for (int k = 1; k <= W; k++) begin
            player_input = seq_a[k];
            check("win_busy", busy, 1);
            check("win_hit", hit_pulse, 0);
            check("win_miss", miss_pulse, 0);
            step();
        end
        model_apply(res);
        check("judge_hit", hit_pulse, (res == 1) ? 1 : 0);
        check("judge_miss", miss_pulse, (res == 2) ? 1 : 0);
        check("judge_score", score, m_score);
        check("judge_combo", combo, m_combo);
        check("judge_overrun", overrun, m_overrun);
        step();
        check("idle_hit", hit_pulse, 0);
        check("idle_miss", miss_pulse, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic set_seq(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [2:0] s3, input logic [2:0] s4);
        seq_a[0] = s0; seq_a[1] = s1; seq_a[2] = s2; seq_a[3] = s3; seq_a[4] = s4;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        m_score = 0; m_combo = 0; m_overrun = 0;
    endtask

    initial begin
        resetn       = 1'b0;
        beat_tick    = 1'b0;
        notes        = 3'b000;
        player_input = 3'b111;
        step();
        step();
        check("rst_score", score, 0);
        check("rst_combo", combo, 0);
        check("rst_hit", hit_pulse, 0);
        check("rst_miss", miss_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        resetn = 1'b1;
        step();

        // Directed hit: press 111 in window cycle 2
        set_seq(3'b000, 3'b000, 3'b111, 3'b111, 3'b111);
        player_input = 3'b000;
        step();
        run_slot(3'b111);
        check("hit_score10", score, 10);
        check("hit_combo1", combo, 1);

        // Wrong press, stray press on empty slot, empty neutral slot
        do_reset();
        set_seq(3'b000, 3'b001, 3'b001, 3'b001, 3'b001);
        run_slot(3'b101);
        check("miss_sat0", score, 0);
        set_seq(3'b000, 3'b000, 3'b010, 3'b000, 3'b000);
        run_slot(3'b000);
        set_seq(3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        run_slot(3'b000);

        // Held buttons: no edge -> miss; edge on last window cycle -> hit
        set_seq(3'b111, 3'b111, 3'b111, 3'b111, 3'b111);
        run_slot(3'b111);
        set_seq(3'b111, 3'b111, 3'b111, 3'b000, 3'b111);
        run_slot(3'b111);
        check("last_cycle_hit_combo", combo, 1);

        // Overrun: second tick two cycles after the first
        beat_tick = 1'b1; notes = 3'b111; player_input = 3'b000;
        step();
        beat_tick = 1'b0;
        step();
        beat_tick = 1'b1; player_input = 3'b111;
        step();
        beat_tick = 1'b0;
        step();
        step();
        check("ovr_judge_hit", hit_pulse, 1);
        check("ovr_flag", overrun, 1);
        model_apply(1);
        m_overrun = 1;
        check("ovr_score", score, m_score);
        step();
        check("ovr_sticky", overrun, 1);
        check("ovr_idle", busy, 0);

        // Reset in window cycle 3 abandons the slot
        beat_tick = 1'b1; notes = 3'b011; player_input = 3'b000;
        step();
        beat_tick = 1'b0;
        player_input = 3'b011;
        step();
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        m_score = 0; m_combo = 0; m_overrun = 0;
        check("mid_rst_score", score, 0);
        check("mid_rst_combo", combo, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_hit", hit_pulse, 0);
        check("mid_rst_miss", miss_pulse, 0);
        for (int k = 0; k < W + 2; k++) begin
            step();
            check("post_rst_hit", hit_pulse, 0);
            check("post_rst_miss", miss_pulse, 0);
        end

        // Randomized slots
        for (int s = 0; s < 80; s++) begin
            logic [2:0] nv;
            int mode;
            int at;
            nv   = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 2);
            at   = $urandom_range(1, W);
            for (int k = 0; k <= W; k++) begin
                if (mode == 0) seq_a[k] = 3'($urandom);
                else if (mode == 1) seq_a[k] = (k >= at) ? nv : 3'b000;
                else seq_a[k] = 3'b000;
            end
            run_slot(nv);
        end

        // Saturation: enough hits to pin score and combo
        set_seq(3'b000, 3'b111, 3'b111, 3'b111, 3'b111);
        for (int s = 0; s < 6554; s++) run_slot(3'b111);
        check("sat_score", score, 65535);
        check("sat_combo", combo, 255);
        run_slot(3'b111);
        check("sat_score_hold", score, 65535);
        check("sat_combo_hold", combo, 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
